// File: rtl/core_multicycle.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with internal register file and ALU.
// Latency: ALU/branch/jump 4 cycles, SW 4, LW 5 with zero-wait memory; each ready=0 cycle adds one.
// Backpressure: IM/DM requests hold address/data stable until the matching ready; ready without a request is ignored.
module core_multicycle #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned RF_DEPTH     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    output logic [WORD_SIZE-1:0] o_IM_addr,
    output logic                 o_IM_req,
    input  logic                 i_IM_ready,
    input  logic [WORD_SIZE-1:0] i_IM_instruction,
    output logic [WORD_SIZE-1:0] o_DM_addr,
    output logic [WORD_SIZE-1:0] o_DM_wd,
    output logic                 o_DM_wen,
    output logic                 o_DM_ren,
    input  logic                 i_DM_ready,
    input  logic [WORD_SIZE-1:0] i_DM_rd,
    output logic                 o_halt
);
    localparam int unsigned W  = WORD_SIZE;
    localparam int unsigned AW = $clog2(RF_DEPTH);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t         state_q, state_d;
    logic           start_q;
    logic [W-1:0]   pc_q, ir_q, rs1_q, rs2_q, imm_q, res_q, npc_q, addr_q, wd_q;
    logic [W-1:0]   rf [RF_DEPTH];

    logic [6:0]     opc, f7;
    logic [2:0]     f3;
    logic [4:0]     rd, rs1, rs2;
    logic           uses_rd, uses_rs1, uses_rs2, legal, is_mem, wr_en;
    logic [W-1:0]   imm_dec, rf_rd1, rf_rd2;
    logic [W-1:0]   op_b, alu_res, sum, target, next_pc, pc_plus4;
    logic [4:0]     shamt;
    logic           taken, redirect, tgt_misalign;

    assign opc      = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign f3       = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign f7       = ir_q[31:25];
    assign uses_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign uses_rs2 = (opc == OP_BR || opc == OP_STORE || opc == OP_REG);
    assign uses_rd  = !(opc == OP_BR || opc == OP_STORE);
    assign is_mem   = (opc == OP_LOAD || opc == OP_STORE);
    assign wr_en    = uses_rd;
    assign rf_rd1   = (rs1 == 5'd0) ? '0 : rf[rs1[AW-1:0]];
    assign rf_rd2   = (rs2 == 5'd0) ? '0 : rf[rs2[AW-1:0]];
    assign pc_plus4 = pc_q + 32'd4;

    // Legality: opcode/funct combinations outside the subset, and upper registers on RV32E.
    always_comb begin
        legal = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:                  legal = (f3 == 3'b000);
            OP_BR:                    legal = (f3 != 3'b010) && (f3 != 3'b011);
            OP_LOAD, OP_STORE:        legal = (f3 == 3'b010);
            OP_IMM:                   legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                                              (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            OP_REG:                   legal = (f7 == 7'h00) ||
                                              (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            default:                  legal = 1'b0;
        endcase
        if (RF_DEPTH < 32 && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]))) begin
            legal = 1'b0;
        end
    end

    // Immediate generation for the I/S/B/U/J formats.
    always_comb begin
        imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
        case (opc)
            OP_STORE:         imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BR:            imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm_dec = {ir_q[31:12], 12'b0};
            OP_JAL:           imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:          imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
    end

    // ALU, branch compare and control-flow target from the latched operands.
    always_comb begin
        op_b    = (opc == OP_REG) ? rs2_q : imm_q;
        shamt   = op_b[4:0];
        sum     = rs1_q + imm_q;
        alu_res = '0;
        case (f3)
            3'b000:  alu_res = (opc == OP_REG && f7[5]) ? rs1_q - op_b : rs1_q + op_b;
            3'b001:  alu_res = rs1_q << shamt;
            3'b010:  alu_res = {{(W-1){1'b0}}, $signed(rs1_q) < $signed(op_b)};
            3'b011:  alu_res = {{(W-1){1'b0}}, rs1_q < op_b};
            3'b100:  alu_res = rs1_q ^ op_b;
            3'b101:  alu_res = f7[5] ? W'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
            3'b110:  alu_res = rs1_q | op_b;
            default: alu_res = rs1_q & op_b;
        endcase
        case (opc)
            OP_LUI:          alu_res = imm_q;
            OP_AUIPC:        alu_res = pc_q + imm_q;
            OP_JAL, OP_JALR: alu_res = pc_plus4;
            default:         ;
        endcase
        case (f3)
            3'b000:  taken = (rs1_q == rs2_q);
            3'b001:  taken = (rs1_q != rs2_q);
            3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  taken = (rs1_q <  rs2_q);
            3'b111:  taken = (rs1_q >= rs2_q);
            default: taken = 1'b0;
        endcase
        target       = (opc == OP_JALR) ? {sum[W-1:1], 1'b0} : pc_q + imm_q;
        redirect     = (opc == OP_JAL) || (opc == OP_JALR) || (opc == OP_BR && taken);
        next_pc      = redirect ? target : pc_plus4;
        tgt_misalign = redirect && (target[1:0] != 2'b00);
    end

    // State register; async reset lands in FETCH with requests held off by start_q.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // Next-state logic; misaligned targets and addresses halt before any side effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (start_q && i_IM_ready) state_d = S_DECODE;
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_mem)            state_d = (sum[1:0] != 2'b00) ? S_HALT : S_MEM;
                else if (tgt_misalign) state_d = S_HALT;
                else                   state_d = S_WB;
            end
            S_MEM:    if (i_DM_ready) state_d = (opc == OP_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // Datapath registers, advanced by the state they belong to.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            start_q <= 1'b0;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            npc_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            start_q <= 1'b1;
            case (state_q)
                S_FETCH:  if (start_q && i_IM_ready) ir_q <= i_IM_instruction;
                S_DECODE: begin
                    rs1_q <= rf_rd1;
                    rs2_q <= rf_rd2;
                    imm_q <= imm_dec;
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    npc_q <= next_pc;
                    if (is_mem && sum[1:0] == 2'b00) begin
                        addr_q <= sum;
                        wd_q   <= rs2_q;
                    end
                end
                S_MEM: begin
                    if (i_DM_ready) begin
                        if (opc == OP_LOAD) res_q <= i_DM_rd;
                        else                pc_q  <= pc_plus4;
                    end
                end
                S_WB:     pc_q <= npc_q;
                default:  ;
            endcase
        end
    end

    // Register file write; x0 is never written so it always reads zero.
    always_ff @(posedge i_clk) begin
        if (state_q == S_WB && wr_en && rd != 5'd0) rf[rd[AW-1:0]] <= res_q;
    end

    assign o_IM_req  = start_q && (state_q == S_FETCH);
    assign o_IM_addr = pc_q;
    assign o_DM_addr = addr_q;
    assign o_DM_wd   = wd_q;
    assign o_DM_wen  = (state_q == S_MEM) && (opc == OP_STORE);
    assign o_DM_ren  = (state_q == S_MEM) && (opc == OP_LOAD);
    assign o_halt    = (state_q == S_HALT);
endmodule

// File: tb/tb_core_multicycle.sv
// Bench for core_multicycle: instruction stream fed per fetch, register values observed through stores.
// Table of directed ALU/branch/jump vectors, then hand sequences for wait states, halts and async reset.
// DM responder inserts dm_wait ready=0 cycles per access.
`timescale 1ns/1ps
module tb_core_multicycle;
    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [31:0] o_IM_addr, i_IM_instruction, o_DM_addr, o_DM_wd, i_DM_rd;
    logic        o_IM_req, i_IM_ready, o_DM_wen, o_DM_ren, i_DM_ready, o_halt;

    always #5 i_clk = ~i_clk;

    core_multicycle #(.WORD_SIZE(32), .RESET_VECTOR(32'h100), .RF_DEPTH(32)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .o_IM_addr(o_IM_addr), .o_IM_req(o_IM_req), .i_IM_ready(i_IM_ready),
        .i_IM_instruction(i_IM_instruction),
        .o_DM_addr(o_DM_addr), .o_DM_wd(o_DM_wd), .o_DM_wen(o_DM_wen), .o_DM_ren(o_DM_ren),
        .i_DM_ready(i_DM_ready), .i_DM_rd(i_DM_rd), .o_halt(o_halt)
    );

    int n_vec = 0, n_bad = 0;
    int cyc = 0, last_hs = 0;
    int ren_cnt = 0, imreq_cnt = 0, both_cnt = 0;
    int dm_wait = 0, dm_cnt = 0;
    logic [31:0] dmem [32];
    logic        dm_ready = 1'b0;
    logic [31:0] dm_rd = '0;
    assign i_DM_ready = dm_ready;
    assign i_DM_rd    = dm_rd;

    initial foreach (dmem[k]) dmem[k] = '0;

    // Cycle counter, activity monitors and store capture.
    always @(posedge i_clk) begin
        cyc++;
        if (o_DM_ren) ren_cnt++;
        if (o_IM_req) imreq_cnt++;
        if (o_DM_ren && o_DM_wen) both_cnt++;
        if (o_DM_wen && i_DM_ready) dmem[o_DM_addr[6:2]] = o_DM_wd;
    end

    // Data memory responder with programmable wait states.
    always @(negedge i_clk) begin
        if (o_DM_wen || o_DM_ren) begin
            if (dm_cnt >= dm_wait) begin
                dm_ready = 1'b1;
                dm_rd    = dmem[o_DM_addr[6:2]];
                dm_cnt   = 0;
            end else begin
                dm_ready = 1'b0;
                dm_cnt++;
            end
        end else begin
            dm_ready = 1'b0;
            dm_cnt   = 0;
        end
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] exp_pc, input string nm);
        int n = 0;
        while (!o_IM_req && n < 100) begin @(negedge i_clk); n++; end
        if (!o_IM_req) begin
            n_vec++; n_bad++;
            $display("FAIL %s: no fetch request within 100 cycles, expected one at %h", nm, exp_pc);
            return;
        end
        chk(nm, o_IM_addr, exp_pc);
        i_IM_instruction = instr;
        i_IM_ready       = 1'b1;
        last_hs          = cyc;
        @(negedge i_clk);
        i_IM_ready       = 1'b0;
    endtask

    task automatic check_store(input logic [31:0] ea, input logic [31:0] ew, input int exp_hold, input string nm);
        int n = 0;
        int hold = 0;
        logic stable = 1'b1;
        while (!o_DM_wen && n < 100) begin @(negedge i_clk); n++; end
        if (!o_DM_wen) begin
            n_vec++; n_bad++;
            $display("FAIL %s: no store within 100 cycles, expected wd %h", nm, ew);
            return;
        end
        chk({nm, "_addr"}, o_DM_addr, ea);
        chk({nm, "_wd"}, o_DM_wd, ew);
        while (o_DM_wen && hold < 100) begin
            if (o_DM_addr !== ea || o_DM_wd !== ew || o_DM_ren) stable = 1'b0;
            hold++;
            @(negedge i_clk);
        end
        if (exp_hold > 0) begin
            chk({nm, "_hold"}, 32'(hold), 32'(exp_hold));
            chk({nm, "_stable"}, {31'b0, stable}, 32'd1);
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge i_clk);
        i_rstn = 1'b0;
        #1;
        chk({nm, "_im_req"}, {31'b0, o_IM_req}, 32'd0);
        chk({nm, "_dm_wen"}, {31'b0, o_DM_wen}, 32'd0);
        chk({nm, "_dm_ren"}, {31'b0, o_DM_ren}, 32'd0);
        chk({nm, "_dm_addr"}, o_DM_addr, 32'd0);
        chk({nm, "_dm_wd"}, o_DM_wd, 32'd0);
        chk({nm, "_halt"}, {31'b0, o_halt}, 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        chk;
        logic [4:0]  rd;
        logic [31:0] val;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];

    initial begin
        logic [31:0] exp_pc;
        int t0, t1, t2, t3, n;

        vt[0]  = '{enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'h13),        32'h104, 1'b1, 5'd1,  32'd5};
        vt[1]  = '{enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2),          32'h10C, 1'b1, 5'd2,  32'd10};
        vt[2]  = '{enc_i(32'hFFF, 5'd0, 3'b000, 5'd4, 7'h13),       32'h114, 1'b1, 5'd4,  32'hFFFF_FFFF};
        vt[3]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd5),          32'h11C, 1'b1, 5'd5,  32'hFFFF_FFFB};
        vt[4]  = '{enc_b(32'hFFFF_FFF8, 5'd1, 5'd4, 3'b100),        32'h118, 1'b0, 5'd0,  32'd0};
        vt[5]  = '{enc_i(32'd1, 5'd0, 3'b000, 5'd0, 7'h13),         32'h11C, 1'b1, 5'd0,  32'd0};
        vt[6]  = '{enc_b(32'hFFFF_FFF8, 5'd1, 5'd4, 3'b110),        32'h124, 1'b0, 5'd0,  32'd0};
        vt[7]  = '{enc_i(32'd0, 5'd4, 3'b010, 5'd6, 7'h13),         32'h128, 1'b1, 5'd6,  32'd1};
        vt[8]  = '{enc_r(7'h00, 5'd4, 5'd1, 3'b011, 5'd7),          32'h130, 1'b1, 5'd7,  32'd1};
        vt[9]  = '{enc_i(32'h401, 5'd5, 3'b101, 5'd8, 7'h13),       32'h138, 1'b1, 5'd8,  32'hFFFF_FFFD};
        vt[10] = '{enc_i(32'd28, 5'd5, 3'b101, 5'd9, 7'h13),        32'h140, 1'b1, 5'd9,  32'h0000_000F};
        vt[11] = '{enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd10),         32'h148, 1'b1, 5'd10, 32'h0000_1400};
        vt[12] = '{enc_i(32'h0F0, 5'd1, 3'b110, 5'd11, 7'h13),      32'h150, 1'b1, 5'd11, 32'h0000_00F5};
        vt[13] = '{enc_i(32'hFFF, 5'd1, 3'b100, 5'd12, 7'h13),      32'h158, 1'b1, 5'd12, 32'hFFFF_FFFA};
        vt[14] = '{enc_u(32'h12345, 5'd13, 7'h37),                  32'h160, 1'b1, 5'd13, 32'h1234_5000};
        vt[15] = '{enc_u(32'h1, 5'd14, 7'h17),                      32'h168, 1'b1, 5'd14, 32'h0000_1164};
        vt[16] = '{enc_b(32'd16, 5'd1, 5'd1, 3'b000),               32'h17C, 1'b0, 5'd0,  32'd0};
        vt[17] = '{enc_b(32'd8, 5'd1, 5'd4, 3'b101),                32'h180, 1'b0, 5'd0,  32'd0};
        vt[18] = '{enc_b(32'd8, 5'd2, 5'd1, 3'b001),                32'h188, 1'b0, 5'd0,  32'd0};
        vt[19] = '{enc_b(32'd8, 5'd1, 5'd4, 3'b111),                32'h190, 1'b0, 5'd0,  32'd0};
        vt[20] = '{enc_j(32'd16, 5'd15),                            32'h1A0, 1'b1, 5'd15, 32'h0000_0194};
        vt[21] = '{enc_i(32'h201, 5'd0, 3'b000, 5'd16, 7'h13),      32'h1A8, 1'b1, 5'd16, 32'h0000_0201};
        vt[22] = '{enc_i(32'd3, 5'd16, 3'b000, 5'd16, 7'h67),       32'h204, 1'b1, 5'd16, 32'h0000_01B0};
        vt[23] = '{enc_r(7'h20, 5'd1, 5'd5, 3'b101, 5'd18),         32'h20C, 1'b1, 5'd18, 32'hFFFF_FFFF};
        vt[24] = '{enc_r(7'h00, 5'd2, 5'd4, 3'b111, 5'd19),         32'h214, 1'b1, 5'd19, 32'h0000_000A};

        i_rstn = 1'b0;
        i_IM_ready = 1'b0;
        i_IM_instruction = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_im_req", {31'b0, o_IM_req}, 32'd0);
        chk("rst_dm_wen", {31'b0, o_DM_wen}, 32'd0);
        chk("rst_dm_ren", {31'b0, o_DM_ren}, 32'd0);
        chk("rst_dm_addr", o_DM_addr, 32'd0);
        chk("rst_dm_wd", o_DM_wd, 32'd0);
        chk("rst_halt", {31'b0, o_halt}, 32'd0);
        i_rstn = 1'b1;

        // Directed vectors: each op followed by a store that exposes its destination register.
        exp_pc = 32'h100;
        for (int i = 0; i < NV; i++) begin
            fetch(vt[i].instr, exp_pc, $sformatf("v%0d_fetch", i));
            if (vt[i].chk) begin
                fetch(enc_s(32'h40, vt[i].rd, 5'd0), vt[i].npc, $sformatf("v%0d_sw_fetch", i));
                check_store(32'h40, vt[i].val, 0, $sformatf("v%0d_rd", i));
                exp_pc = vt[i].npc + 32'd4;
            end else begin
                exp_pc = vt[i].npc;
            end
        end

        // Wait-stated SW then LW round trip, with handshake-to-handshake latency.
        dm_wait = 3;
        fetch(enc_s(32'd8, 5'd2, 5'd0), exp_pc, "sw_wait_fetch");
        t0 = last_hs;
        check_store(32'd8, 32'd10, 4, "sw_wait");
        fetch(enc_i(32'd8, 5'd0, 3'b010, 5'd3, 7'h03), exp_pc + 32'd4, "lw_fetch");
        t1 = last_hs;
        chk("sw_latency", 32'(t1 - t0), 32'd7);
        fetch(enc_s(32'h40, 5'd3, 5'd0), exp_pc + 32'd8, "lw_chk_fetch");
        t2 = last_hs;
        chk("lw_latency", 32'(t2 - t1), 32'd8);
        check_store(32'h40, 32'd10, 4, "lw_data");
        dm_wait = 0;
        fetch(enc_i(32'd1, 5'd0, 3'b000, 5'd17, 7'h13), exp_pc + 32'd12, "addi_fetch");
        t3 = last_hs;
        fetch(32'h0000_007F, exp_pc + 32'd16, "illegal_fetch");
        chk("alu_latency", 32'(last_hs - t3), 32'd4);
        repeat (2) @(negedge i_clk);
        imreq_cnt = 0;
        repeat (6) @(negedge i_clk);
        chk("illegal_halt", {31'b0, o_halt}, 32'd1);
        chk("illegal_no_fetch", 32'(imreq_cnt), 32'd0);

        // Misaligned load halts without a DM request.
        do_reset("rst2");
        ren_cnt = 0;
        fetch(enc_i(32'd6, 5'd0, 3'b010, 5'd3, 7'h03), 32'h100, "lw_mis_fetch");
        repeat (3) @(negedge i_clk);
        imreq_cnt = 0;
        repeat (6) @(negedge i_clk);
        chk("lw_mis_halt", {31'b0, o_halt}, 32'd1);
        chk("lw_mis_no_ren", 32'(ren_cnt), 32'd0);
        chk("lw_mis_no_fetch", 32'(imreq_cnt), 32'd0);

        // Misaligned jump target halts and stops fetching.
        do_reset("rst3");
        fetch(enc_j(32'd2, 5'd1), 32'h100, "jal_mis_fetch");
        repeat (3) @(negedge i_clk);
        imreq_cnt = 0;
        repeat (6) @(negedge i_clk);
        chk("jal_mis_halt", {31'b0, o_halt}, 32'd1);
        chk("jal_mis_no_fetch", 32'(imreq_cnt), 32'd0);

        // Async reset in the middle of a stalled store.
        do_reset("rst4");
        dm_wait = 50;
        fetch(enc_s(32'd8, 5'd2, 5'd0), 32'h100, "sw_abort_fetch");
        n = 0;
        while (!o_DM_wen && n < 20) begin @(negedge i_clk); n++; end
        chk("sw_abort_wen_up", {31'b0, o_DM_wen}, 32'd1);
        #2 i_rstn = 1'b0;
        #1;
        chk("sw_abort_wen_drop", {31'b0, o_DM_wen}, 32'd0);
        chk("sw_abort_im_req", {31'b0, o_IM_req}, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        dm_wait = 0;
        fetch(enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'h13), 32'h100, "restart_fetch");
        chk("restart_halt", {31'b0, o_halt}, 32'd0);
        chk("ren_wen_exclusive", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
